// File: rtl/game_pkg.sv
// Shared types, display character codes and widths for the game mode sequencer.
package game_pkg;

  typedef enum logic [1:0] {StMenu, StBanner, StPlay, StExit} state_e;

  localparam int unsigned LED_W  = 16;
  localparam int unsigned SEG_W  = 20;
  localparam int unsigned CHAR_W = 5;

  localparam logic [CHAR_W-1:0] C_BLANK = 5'd31;
  localparam logic [CHAR_W-1:0] C_P     = 5'd16;
  localparam logic [CHAR_W-1:0] C_U     = 5'd15;
  localparam logic [CHAR_W-1:0] C_d     = 5'd19;
  localparam logic [CHAR_W-1:0] C_n     = 5'd20;
  localparam logic [CHAR_W-1:0] C_g     = 5'd9;
  localparam logic [CHAR_W-1:0] C_o     = 5'd17;

  // Menu digits are 1-based on the display, so index 0 shows as "1".
  function automatic logic [CHAR_W-1:0] digit_char(input logic [3:0] idx);
    return {1'b0, idx} + 5'd1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector; prev resets high so a button held through reset never fires.
module btn_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!reset_n) prev_q <= 1'b1;
    else          prev_q <= btn;
  end

  assign rise = btn & ~prev_q;

endmodule

// File: rtl/game_mode_scheduler.sv
// Menu / banner / play / exit sequencer that owns the shared LEDs and display and
// hands the go/stop button and an active flag to the selected game mode.
module game_mode_scheduler
  import game_pkg::*;
#(
  parameter int unsigned NUM_MODES        = 3,
  parameter int unsigned BANNER_CYCLES    = 100_000_000,
  parameter int unsigned DONE_HOLD_CYCLES = 300_000_000,
  parameter int unsigned CNT_W            = 29
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        btn_next,
  input  logic                        btn_enter,
  input  logic                        btn_back,
  input  logic                        btn_go_stop_in,
  input  logic [NUM_MODES-1:0]        mode_done,
  input  logic [LED_W*NUM_MODES-1:0]  mode_led_bus,
  input  logic [SEG_W*NUM_MODES-1:0]  mode_seg_bus,
  output logic [NUM_MODES-1:0]        mode_active,
  output logic [NUM_MODES-1:0]        btn_go_stop_out,
  output logic [LED_W-1:0]            led,
  output logic [SEG_W-1:0]            seg_data,
  output logic [3:0]                  sel
);

  localparam logic [CNT_W-1:0] BannerLast = CNT_W'(BANNER_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(DONE_HOLD_CYCLES - 1);
  localparam logic [3:0]       SelLast    = 4'(NUM_MODES - 1);

  logic next_rise, enter_rise, back_rise;

  btn_edge u_next  (.clk(clk), .reset_n(reset_n), .btn(btn_next),  .rise(next_rise));
  btn_edge u_enter (.clk(clk), .reset_n(reset_n), .btn(btn_enter), .rise(enter_rise));
  btn_edge u_back  (.clk(clk), .reset_n(reset_n), .btn(btn_back),  .rise(back_rise));

  state_e               state_q, state_d;
  logic [3:0]           sel_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [NUM_MODES-1:0] sel_onehot;
  logic [LED_W-1:0]     led_slice;
  logic [SEG_W-1:0]     seg_slice;

  assign sel_onehot = {{(NUM_MODES-1){1'b0}}, 1'b1} << sel;
  assign led_slice  = mode_led_bus[LED_W*int'(sel) +: LED_W];
  assign seg_slice  = mode_seg_bus[SEG_W*int'(sel) +: SEG_W];

  always_comb begin
    state_d = state_q;
    sel_d   = sel;
    cnt_d   = cnt_q;
    done_d  = done_q;
    unique case (state_q)
      StMenu: begin
        // Enter wins over a same-cycle next, leaving the selection untouched.
        if (enter_rise) begin
          state_d = StBanner;
          cnt_d   = '0;
        end else if (next_rise) begin
          sel_d = (sel == SelLast) ? 4'd0 : sel + 4'd1;
        end
      end
      StBanner: begin
        if (back_rise) begin
          state_d = StMenu;
        end else if (cnt_q == BannerLast) begin
          state_d = StPlay;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StPlay: begin
        // Once latched, the hold runs to completion even if mode_done drops.
        if (back_rise) begin
          state_d = StExit;
        end else if (done_q) begin
          if (cnt_q == HoldLast) state_d = StExit;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end else if (|(mode_done & sel_onehot)) begin
          done_d = 1'b1;
          cnt_d  = '0;
        end
      end
      StExit: begin
        state_d = StMenu;
        done_d  = 1'b0;
      end
      default: state_d = StMenu;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= StMenu;
      sel             <= 4'd0;
      cnt_q           <= '0;
      done_q          <= 1'b0;
      mode_active     <= '0;
      btn_go_stop_out <= '0;
      led             <= '0;
      seg_data        <= {C_P, C_BLANK, C_BLANK, digit_char(4'd0)};
    end else begin
      state_q         <= state_d;
      sel             <= sel_d;
      cnt_q           <= cnt_d;
      done_q          <= done_d;
      mode_active     <= '0;
      btn_go_stop_out <= '0;
      led             <= '0;
      // Outputs follow the state being entered so they line up with state_q.
      unique case (state_d)
        StMenu:   seg_data <= {C_P, C_BLANK, C_BLANK, digit_char(sel_d)};
        StBanner: begin
          led      <= '1;
          seg_data <= {4{digit_char(sel_d)}};
        end
        StPlay: begin
          mode_active     <= sel_onehot;
          btn_go_stop_out <= sel_onehot & {NUM_MODES{btn_go_stop_in}};
          led             <= led_slice;
          seg_data        <= seg_slice;
        end
        StExit:   seg_data <= {4{C_BLANK}};
        default:  seg_data <= {4{C_BLANK}};
      endcase
    end
  end

endmodule

// File: tb/tb_game_mode_scheduler.sv
// Self-checking bench for game_mode_scheduler: directed scenarios plus a randomized run,
// all compared against a countdown-based behavioural model of the menu/banner/play flow.
module tb_game_mode_scheduler;

  localparam int unsigned N = 3;
  localparam int unsigned B = 4;
  localparam int unsigned H = 8;

  localparam int PhMenu   = 0;
  localparam int PhBanner = 1;
  localparam int PhPlay   = 2;
  localparam int PhExit   = 3;

  localparam logic [19:0] SegMenu1 = {5'd16, 5'd31, 5'd31, 5'd1};
  localparam logic [19:0] SegMenu2 = {5'd16, 5'd31, 5'd31, 5'd2};
  localparam logic [19:0] SegBlank = {5'd31, 5'd31, 5'd31, 5'd31};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_next = 1'b0, btn_enter = 1'b0, btn_back = 1'b0, btn_go_stop_in = 1'b0;
  logic [N-1:0]    mode_done = '0;
  logic [16*N-1:0] mode_led_bus = '0;
  logic [20*N-1:0] mode_seg_bus = '0;
  logic [N-1:0]    mode_active, btn_go_stop_out;
  logic [15:0]     led;
  logic [19:0]     seg_data;
  logic [3:0]      sel;

  game_mode_scheduler #(
    .NUM_MODES(N), .BANNER_CYCLES(B), .DONE_HOLD_CYCLES(H), .CNT_W(29)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_next(btn_next), .btn_enter(btn_enter),
    .btn_back(btn_back), .btn_go_stop_in(btn_go_stop_in), .mode_done(mode_done),
    .mode_led_bus(mode_led_bus), .mode_seg_bus(mode_seg_bus), .mode_active(mode_active),
    .btn_go_stop_out(btn_go_stop_out), .led(led), .seg_data(seg_data), .sel(sel)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: phase plus cycles-left countdown.
  int ph = PhMenu, left = 0, msel = 0;
  bit held = 1'b0, p_next = 1'b1, p_enter = 1'b1, p_back = 1'b1;
  logic [N-1:0] e_active, e_go;
  logic [15:0]  e_led;
  logic [19:0]  e_seg;

  task automatic model_step();
    bit nr, er, br;
    nr = btn_next && !p_next;
    er = btn_enter && !p_enter;
    br = btn_back && !p_back;
    if (!reset_n) begin
      ph = PhMenu; msel = 0; held = 1'b0; left = 0;
      p_next = 1'b1; p_enter = 1'b1; p_back = 1'b1;
    end else begin
      p_next = btn_next; p_enter = btn_enter; p_back = btn_back;
      case (ph)
        PhMenu: begin
          if (er) begin ph = PhBanner; left = B; end
          else if (nr) msel = (msel + 1) % N;
        end
        PhBanner: begin
          if (br) ph = PhMenu;
          else begin
            left--;
            if (left == 0) begin ph = PhPlay; held = 1'b0; end
          end
        end
        PhPlay: begin
          if (br) ph = PhExit;
          else if (held) begin
            left--;
            if (left == 0) ph = PhExit;
          end else if (mode_done[msel]) begin
            held = 1'b1; left = H;
          end
        end
        default: begin ph = PhMenu; held = 1'b0; end
      endcase
    end
    e_active = '0; e_go = '0; e_led = '0;
    case (ph)
      PhMenu:   e_seg = {5'd16, 5'd31, 5'd31, 5'(msel + 1)};
      PhBanner: begin e_led = 16'hFFFF; e_seg = {4{5'(msel + 1)}}; end
      PhPlay: begin
        e_active[msel] = 1'b1;
        e_go[msel]     = btn_go_stop_in;
        e_led          = mode_led_bus[16*msel +: 16];
        e_seg          = mode_seg_bus[20*msel +: 20];
      end
      default:  e_seg = SegBlank;
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_buses();
    for (int k = 0; k < int'(N); k++) begin
      mode_led_bus[16*k +: 16] = 16'($urandom);
      mode_seg_bus[20*k +: 20] = 20'($urandom);
    end
  endtask

  task automatic press_next();
    btn_next = 1'b1; tick(); btn_next = 1'b0; tick();
  endtask

  task automatic goto_sel(input int s);
    for (int i = 0; i < 8 && msel != s; i++) press_next();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; btn_next = 1'b1;
    tick(); tick();
    vectors++;
    if ({mode_active, btn_go_stop_out, led, seg_data, sel} !== {3'b0, 3'b0, 16'h0, SegMenu1, 4'd0}) begin
      miscompares++;
      $display("FAIL reset_values: got %h %h %h %h %h", mode_active, btn_go_stop_out, led, seg_data, sel);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (sel !== 4'd0 || seg_data !== e_seg) begin
        miscompares++;
        $display("FAIL held_next_after_reset: sel %0d seg %h, expected sel 0 seg %h", sel, seg_data, e_seg);
      end
    end
    btn_next = 1'b0; tick();
  endtask

  task automatic test_menu_next();
    logic [3:0] want;
    for (int i = 0; i < 3; i++) begin
      press_next();
      want = 4'((i + 1) % 3);
      vectors++;
      if (sel !== want || seg_data !== {5'd16, 5'd31, 5'd31, 5'(want + 1)} || led !== 16'h0
          || {mode_active, btn_go_stop_out, led, seg_data, sel} !== {e_active, e_go, e_led, e_seg, 4'(msel)}) begin
        miscompares++;
        $display("FAIL menu_next_%0d: sel %0d seg %h led %h, expected sel %0d", i, sel, seg_data, led, want);
      end
    end
  endtask

  task automatic test_banner_play();
    goto_sel(1);
    btn_enter = 1'b1; tick(); btn_enter = 1'b0;
    for (int i = 0; i < int'(B); i++) begin
      vectors++;
      if (led !== 16'hFFFF || seg_data !== {4{5'd2}} || mode_active !== 3'b000) begin
        miscompares++;
        $display("FAIL banner_cycle_%0d: led %h seg %h active %b, expected FFFF 2222 000", i, led, seg_data, mode_active);
      end
      tick();
    end
    vectors++;
    if (mode_active !== 3'b010) begin
      miscompares++;
      $display("FAIL play_active: got %b expected 010", mode_active);
    end
    randomize_buses();
    mode_led_bus[31:16] = 16'h00FF;
    mode_seg_bus[39:20] = 20'h12345;
    btn_go_stop_in = 1'b1;
    tick();
    vectors++;
    if (led !== 16'h00FF || seg_data !== 20'h12345 || btn_go_stop_out !== 3'b010
        || {mode_active, btn_go_stop_out, led, seg_data, sel} !== {e_active, e_go, e_led, e_seg, 4'(msel)}) begin
      miscompares++;
      $display("FAIL play_route: led %h seg %h go %b, expected 00FF 12345 010", led, seg_data, btn_go_stop_out);
    end
    btn_go_stop_in = 1'b0;
  endtask

  task automatic test_done_hold();
    int n;
    mode_done = 3'b001; tick();
    vectors++;
    if (mode_active !== 3'b010 || {mode_active, btn_go_stop_out, led, seg_data, sel} !== {e_active, e_go, e_led, e_seg, 4'(msel)}) begin
      miscompares++;
      $display("FAIL unselected_done: active %b, expected 010", mode_active);
    end
    mode_done = 3'b010; tick(); mode_done = 3'b000;
    n = 0;
    while (mode_active !== 3'b000 && n < 20) begin
      vectors++;
      if ({mode_active, btn_go_stop_out, led, seg_data, sel} !== {e_active, e_go, e_led, e_seg, 4'(msel)}) begin
        miscompares++;
        $display("FAIL hold_track_%0d: led %h seg %h, expected %h %h", n, led, seg_data, e_led, e_seg);
      end
      n++;
      randomize_buses();
      tick();
    end
    vectors++;
    if (n != int'(H)) begin
      miscompares++;
      $display("FAIL hold_length: got %0d cycles expected %0d", n, H);
    end
    vectors++;
    if (seg_data !== SegBlank || led !== 16'h0 || btn_go_stop_out !== 3'b000) begin
      miscompares++;
      $display("FAIL exit_cycle: seg %h led %h go %b, expected all-blank 0 000", seg_data, led, btn_go_stop_out);
    end
    tick();
    vectors++;
    if (seg_data !== SegMenu2 || sel !== 4'd1 || mode_active !== 3'b000) begin
      miscompares++;
      $display("FAIL back_to_menu: seg %h sel %0d, expected %h sel 1", seg_data, sel, SegMenu2);
    end
  endtask

  task automatic test_back();
    btn_enter = 1'b1; tick(); btn_enter = 1'b0; tick();
    btn_back = 1'b1; tick(); btn_back = 1'b0;
    vectors++;
    if (mode_active !== 3'b000 || led !== 16'h0 || seg_data !== SegMenu2
        || {mode_active, btn_go_stop_out, led, seg_data, sel} !== {e_active, e_go, e_led, e_seg, 4'(msel)}) begin
      miscompares++;
      $display("FAIL back_in_banner: active %b led %h seg %h, expected 000 0 %h", mode_active, led, seg_data, SegMenu2);
    end
    tick();
    btn_enter = 1'b1; tick(); btn_enter = 1'b0;
    for (int i = 0; i < int'(B); i++) tick();
    mode_done = 3'b010; tick(); mode_done = 3'b000;
    for (int i = 0; i < int'(H) - 1; i++) tick();
    btn_back = 1'b1; tick(); btn_back = 1'b0;
    vectors++;
    if (seg_data !== SegBlank || mode_active !== 3'b000
        || {mode_active, btn_go_stop_out, led, seg_data, sel} !== {e_active, e_go, e_led, e_seg, 4'(msel)}) begin
      miscompares++;
      $display("FAIL back_at_expiry: seg %h active %b, expected %h 000", seg_data, mode_active, SegBlank);
    end
    tick();
    vectors++;
    if (seg_data !== SegMenu2 || sel !== 4'd1) begin
      miscompares++;
      $display("FAIL menu_after_expiry: seg %h sel %0d, expected %h 1", seg_data, sel, SegMenu2);
    end
  endtask

  task automatic test_next_enter_same();
    goto_sel(0);
    btn_next = 1'b1; btn_enter = 1'b1; tick(); btn_next = 1'b0; btn_enter = 1'b0;
    vectors++;
    if (sel !== 4'd0 || led !== 16'hFFFF || seg_data !== {4{5'd1}}
        || {mode_active, btn_go_stop_out, led, seg_data, sel} !== {e_active, e_go, e_led, e_seg, 4'(msel)}) begin
      miscompares++;
      $display("FAIL next_enter_same: sel %0d led %h seg %h, expected 0 FFFF 08421", sel, led, seg_data);
    end
    btn_back = 1'b1; tick(); btn_back = 1'b0; tick();
  endtask

  task automatic test_reset_mid_play();
    goto_sel(2);
    btn_enter = 1'b1; tick(); btn_enter = 1'b0;
    for (int i = 0; i < int'(B) + 1; i++) begin randomize_buses(); tick(); end
    reset_n = 1'b0; tick();
    vectors++;
    if ({mode_active, btn_go_stop_out, led, seg_data, sel} !== {3'b0, 3'b0, 16'h0, SegMenu1, 4'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_play: active %b led %h seg %h sel %0d", mode_active, led, seg_data, sel);
    end
    reset_n = 1'b1; tick();
    vectors++;
    if ({mode_active, btn_go_stop_out, led, seg_data, sel} !== {e_active, e_go, e_led, e_seg, 4'(msel)}) begin
      miscompares++;
      $display("FAIL after_reset_release: seg %h sel %0d, expected %h %0d", seg_data, sel, e_seg, msel);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      btn_next       = ($urandom_range(0, 7) == 0);
      btn_enter      = ($urandom_range(0, 15) == 0);
      btn_back       = ($urandom_range(0, 40) == 0);
      btn_go_stop_in = 1'($urandom);
      for (int k = 0; k < int'(N); k++) mode_done[k] = ($urandom_range(0, 15) == 0);
      reset_n        = ($urandom_range(0, 499) != 0);
      randomize_buses();
      tick();
      vectors++;
      if ({mode_active, btn_go_stop_out, led, seg_data, sel} !== {e_active, e_go, e_led, e_seg, 4'(msel)}) begin
        miscompares++;
        $display("FAIL random_%0d: act %b go %b led %h seg %h sel %0d, expected %b %b %h %h %0d", i,
                 mode_active, btn_go_stop_out, led, seg_data, sel, e_active, e_go, e_led, e_seg, msel);
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_menu_next();
    test_banner_play();
    test_done_hold();
    test_back();
    test_next_enter_same();
    test_reset_mid_play();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
